// File: rtl/nonrestoring_divider.sv
// Iterative radix-2 non-restoring divider: one quotient bit per enabled cycle,
// DIV/DIVU/REM/REMU semantics including divide-by-zero and signed overflow.
package nonrestoring_divider_pkg;
  typedef enum logic {FREE = 1'b0, BUSY = 1'b1} fu_state_e;
endpackage

module nonrestoring_divider
  import nonrestoring_divider_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            clk_en_i,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            valid_o,
  output fu_state_e       fu_state_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, RESTORE} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]         quotient_q, quotient_d;
  logic [XLEN-1:0]         remainder_q, remainder_d;
  logic                    valid_q, valid_d;

  logic signed [XLEN:0]    rem_q, rem_d;
  logic [XLEN-1:0]         quo_q, quo_d;
  logic [XLEN-1:0]         dvs_q, dvs_d;
  logic                    neg_quo_q, neg_quo_d;
  logic                    neg_rem_q, neg_rem_d;
  logic                    special_q, special_d;

  logic                    div_zero, sgn_ovf;
  logic signed [XLEN:0]    dvs_ext, shifted, step, fixed;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    valid_d     = 1'b0;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    special_d   = special_q;

    div_zero = (divisor_i == '0);
    sgn_ovf  = signed_i && (dividend_i == MIN_NEG) && (&divisor_i);

    // Partial remainder may transiently wrap; the post-add/sub value always fits.
    dvs_ext = {1'b0, dvs_q};
    shifted = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    step    = rem_q[XLEN] ? (shifted + dvs_ext) : (shifted - dvs_ext);
    fixed   = step[XLEN] ? (step + dvs_ext) : step;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          neg_quo_d = signed_i && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
          neg_rem_d = signed_i && dividend_i[XLEN-1];
          cnt_d     = '0;
          if (div_zero) begin
            quo_d     = '1;
            rem_d     = {1'b0, dividend_i};
            special_d = 1'b1;
            state_d   = RESTORE;
          end else if (sgn_ovf) begin
            quo_d     = MIN_NEG;
            rem_d     = '0;
            special_d = 1'b1;
            state_d   = RESTORE;
          end else begin
            quo_d     = cond_neg(dividend_i, signed_i && dividend_i[XLEN-1]);
            dvs_d     = cond_neg(divisor_i, signed_i && divisor_i[XLEN-1]);
            rem_d     = '0;
            special_d = 1'b0;
            state_d   = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        quo_d = {quo_q[XLEN-2:0], ~step[XLEN]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          rem_d   = fixed;
          state_d = RESTORE;
        end else begin
          rem_d = step;
        end
      end
      RESTORE: begin
        if (special_q) begin
          quotient_d  = quo_q;
          remainder_d = rem_q[XLEN-1:0];
        end else begin
          quotient_d  = cond_neg(quo_q, neg_quo_q);
          remainder_d = cond_neg(rem_q[XLEN-1:0], neg_rem_q);
        end
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      valid_q     <= 1'b0;
    end else if (clk_en_i) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      valid_q     <= valid_d;
    end
  end

  // Working datapath is fully reloaded on every accepted start, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (clk_en_i) begin
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      special_q <= special_d;
    end
  end

  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign valid_o     = valid_q;
  assign fu_state_o  = (state_q == IDLE) ? FREE : BUSY;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Randomized self-checking bench for nonrestoring_divider against a plain
// arithmetic model of DIV/DIVU/REM/REMU.
module tb_nonrestoring_divider;
  import nonrestoring_divider_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        clk_en_i;
  logic        start_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;
  logic        valid_o;
  fu_state_e   fu_state_o;

  int passed = 0;
  int total  = 0;

  nonrestoring_divider #(.XLEN(32)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .clk_en_i    (clk_en_i),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .valid_o     (valid_o),
    .fu_state_o  (fu_state_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #3000000;
    $display("FAIL global_timeout simulation did not finish, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (s) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b, input logic s);
    return (b == 32'd0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    dividend_i = a;
    divisor_i  = b;
    signed_i   = s;
    start_i    = 1'b1;
    tick();
    start_i    = 1'b0;
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input string name, input bit fall);
    logic [31:0] eq, er, pq, pr;
    int lat, busy;
    bit held, spc, lat_ok;
    model(a, b, s, eq, er);
    spc  = is_special(a, b, s);
    pq   = quotient_o;
    pr   = remainder_o;
    held = 1'b1;
    lat  = -1;
    launch(a, b, s);
    busy = (fu_state_o == BUSY) ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (valid_o) begin
        lat = i;
        break;
      end
      if (fu_state_o == BUSY) busy++;
      if (quotient_o !== pq || remainder_o !== pr) held = 1'b0;
    end
    total++;
    if (!held) $display("FAIL %s_held outputs changed before valid_o", name);
    else passed++;
    lat_ok = spc ? (lat >= 1 && lat <= 2) : (lat == 33);
    total++;
    if (!lat_ok) $display("FAIL %s_latency got %0d edges, expected %s", name, lat, spc ? "<=2" : "33");
    else passed++;
    total++;
    if (busy != lat) $display("FAIL %s_busy BUSY for %0d cycles, expected %0d", name, busy, lat);
    else passed++;
    total++;
    if (quotient_o !== eq) $display("FAIL %s_quotient got %h expected %h", name, quotient_o, eq);
    else passed++;
    total++;
    if (remainder_o !== er) $display("FAIL %s_remainder got %h expected %h", name, remainder_o, er);
    else passed++;
    if (fall) begin
      tick();
      total++;
      if (valid_o !== 1'b0 || fu_state_o !== FREE)
        $display("FAIL %s_after valid=%b fu=%0d expected valid=0 fu=FREE", name, valid_o, fu_state_o);
      else passed++;
      total++;
      if (quotient_o !== eq || remainder_o !== er)
        $display("FAIL %s_hold got %h/%h expected %h/%h", name, quotient_o, remainder_o, eq, er);
      else passed++;
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; clk_en_i = 1'b1; start_i = 1'b0; signed_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    #22;
    total++;
    if (quotient_o !== 32'd0 || remainder_o !== 32'd0)
      $display("FAIL reset_outputs got %h/%h expected 0/0", quotient_o, remainder_o);
    else passed++;
    total++;
    if (valid_o !== 1'b0 || fu_state_o !== FREE)
      $display("FAIL reset_ctrl valid=%b fu=%0d expected 0/FREE", valid_o, fu_state_o);
    else passed++;
    tick();
    rst_n_i = 1'b1;
  endtask

  task automatic test_unsigned();
    do_div(32'd100, 32'd7, 1'b0, "u100_7", 1'b1);
  endtask

  task automatic test_signed();
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, "sm7_2", 1'b1);
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, "s7_m2", 1'b1);
    do_div(32'h8000_0000, 32'd3, 1'b1, "smin_3", 1'b1);
  endtask

  task automatic test_special();
    do_div(32'd5, 32'd0, 1'b0, "u5_0", 1'b1);
    do_div(32'd5, 32'd0, 1'b1, "s5_0", 1'b1);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_ovf", 1'b1);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "u_ovf_ops", 1'b1);
    do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "u_max", 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic s;
    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom_range(1, 255);
        1: b = 32'd0;
        2: b = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      s = 1'($urandom_range(0, 1));
      do_div(a, b, s, "rand", 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    lat = -1;
    launch(32'd100, 32'd7, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      if (i == 10) begin
        dividend_i = 32'd9; divisor_i = 32'd3; start_i = 1'b1;
      end
      tick();
      start_i = 1'b0;
      if (valid_o) begin
        lat = i;
        break;
      end
    end
    total++;
    if (lat != 33) $display("FAIL busy_ignore_latency got %0d expected 33", lat);
    else passed++;
    total++;
    if (quotient_o !== 32'd14 || remainder_o !== 32'd2)
      $display("FAIL busy_ignore_result got %0d/%0d expected 14/2", quotient_o, remainder_o);
    else passed++;
    do_div(32'd9, 32'd3, 1'b0, "b2b_9_3", 1'b0);
    do_div($urandom, $urandom_range(1, 1000), 1'b1, "b2b_rand", 1'b1);
  endtask

  task automatic test_clk_en();
    logic [31:0] pq, pr;
    int edges;
    bit frozen;
    pq = quotient_o;
    pr = remainder_o;
    edges = 0;
    frozen = 1'b1;
    launch(32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 10; i++) begin tick(); edges++; end
    clk_en_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); edges++;
      if (valid_o !== 1'b0 || fu_state_o !== BUSY || quotient_o !== pq || remainder_o !== pr)
        frozen = 1'b0;
    end
    clk_en_i = 1'b1;
    total++;
    if (!frozen) $display("FAIL clk_en_frozen outputs or state moved while disabled");
    else passed++;
    for (int i = 0; i < 40; i++) begin
      tick(); edges++;
      if (valid_o) break;
    end
    total++;
    if (!valid_o || edges != 38) $display("FAIL clk_en_latency got %0d edges expected 38", edges);
    else passed++;
    total++;
    if (quotient_o !== 32'd14 || remainder_o !== 32'd2)
      $display("FAIL clk_en_result got %0d/%0d expected 14/2", quotient_o, remainder_o);
    else passed++;
    tick();
  endtask

  task automatic test_reset_abort();
    bit saw_valid;
    launch(32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 14; i++) tick();
    #2;
    rst_n_i = 1'b0;
    #1;
    total++;
    if (quotient_o !== 32'd0 || remainder_o !== 32'd0)
      $display("FAIL abort_outputs got %h/%h expected 0/0", quotient_o, remainder_o);
    else passed++;
    total++;
    if (valid_o !== 1'b0 || fu_state_o !== FREE)
      $display("FAIL abort_ctrl valid=%b fu=%0d expected 0/FREE", valid_o, fu_state_o);
    else passed++;
    tick();
    tick();
    rst_n_i = 1'b1;
    do_div(32'hFFFF_FC18, 32'd33, 1'b1, "post_reset", 1'b1);
    saw_valid = 1'b0;
    for (int i = 0; i < 36; i++) begin
      tick();
      if (valid_o) saw_valid = 1'b1;
    end
    total++;
    if (saw_valid) $display("FAIL idle_no_valid got a valid_o pulse with no start");
    else passed++;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_back_to_back();
    test_clk_en();
    test_unsigned();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
